// File: rtl/row_activate_ctrl.sv
// Single-bank-at-a-time DDR row activation controller: tracks open rows per bank and
// sequences PRECHARGE/ACTIVE under tRRD, tRAS, tRP and tRCD before signalling DONE.
module row_activate_ctrl #(
    parameter int ROW_W  = 13,
    parameter int BANK_W = 2,
    parameter int T_RCD  = 3,
    parameter int T_RRD  = 2,
    parameter int T_RP   = 3,
    parameter int T_RAS  = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   REQ_VALID,
    input  logic [BANK_W-1:0]      REQ_BANK,
    input  logic [ROW_W-1:0]       REQ_ROW,
    output logic                   REQ_READY,
    output logic                   DONE,
    output logic                   HIT,
    output logic [(2**BANK_W)-1:0] ROW_OPEN,
    output logic                   CKE,
    output logic                   RAS,
    output logic                   CAS,
    output logic                   WE,
    output logic [BANK_W-1:0]      BA,
    output logic [ROW_W-1:0]       ADDR
);
    localparam int NB      = 2**BANK_W;
    localparam int RRD_W   = $clog2(T_RRD + 1);
    localparam int RAS_W   = $clog2(T_RAS + 1);
    localparam int TMR_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [RRD_W-1:0] RRD_SAT  = RRD_W'(T_RRD);
    localparam logic [RAS_W-1:0] RAS_SAT  = RAS_W'(T_RAS);
    localparam logic [TMR_W-1:0] RCD_LOAD = TMR_W'((T_RCD > 1) ? T_RCD - 2 : 0);
    localparam logic [TMR_W-1:0] RP_LOAD  = TMR_W'((T_RP > 1) ? T_RP - 2 : 0);

    // IDLE accept | PRE wait tRAS, precharge | WAIT_RP | ACT wait tRRD, activate | WAIT_RCD | RESP done
    typedef enum logic [2:0] {IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, RESP} state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [BANK_W-1:0]  bank_q, cur_bank;
    logic [ROW_W-1:0]   row_q, cur_row;
    logic               hit_q, hit_now, accept;
    logic [NB-1:0]      open_q;
    logic [ROW_W-1:0]   row_tab_q [NB];
    logic [RRD_W-1:0]   rrd_q, rrd_inc;
    logic [RAS_W-1:0]   ras_cnt_q [NB];
    logic [RAS_W-1:0]   ras_inc [NB];
    logic               act_q, pre_q, act_d, pre_d;
    logic               cke_q, ras_cmd_q, we_cmd_q;
    logic [BANK_W-1:0]  ba_q;
    logic [ROW_W-1:0]   addr_q;

    assign accept   = REQ_VALID && REQ_READY;
    assign cur_bank = (state_q == IDLE) ? REQ_BANK : bank_q;
    assign cur_row  = (state_q == IDLE) ? REQ_ROW : row_q;
    assign hit_now  = open_q[REQ_BANK] && (row_tab_q[REQ_BANK] == REQ_ROW);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hit_now)               state_d = RESP;
                    else if (open_q[REQ_BANK]) state_d = PRE;
                    else                       state_d = ACT;
                end
            end
            PRE: begin
                if (pre_q) begin
                    if (T_RP > 1) begin
                        state_d = WAIT_RP;
                        tmr_d   = RP_LOAD;
                    end else begin
                        state_d = ACT;
                    end
                end
            end
            WAIT_RP: begin
                if (tmr_q == '0) state_d = ACT;
                else             tmr_d   = tmr_q - 1'b1;
            end
            ACT: begin
                if (act_q) begin
                    if (T_RCD > 1) begin
                        state_d = WAIT_RCD;
                        tmr_d   = RCD_LOAD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT_RCD: begin
                if (tmr_q == '0) state_d = RESP;
                else             tmr_d   = tmr_q - 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Commands are decided one cycle ahead so the registered bus shows them in the state's own cycle.
    always_comb begin
        rrd_inc = (rrd_q == RRD_SAT) ? rrd_q : rrd_q + 1'b1;
        for (int b = 0; b < NB; b++) begin
            ras_inc[b] = (ras_cnt_q[b] == RAS_SAT) ? ras_cnt_q[b] : ras_cnt_q[b] + 1'b1;
        end
        act_d = (state_d == ACT) && (rrd_inc >= RRD_SAT);
        pre_d = (state_d == PRE) && (ras_inc[cur_bank] >= RAS_SAT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bank_q    <= '0;
            row_q     <= '0;
            hit_q     <= 1'b0;
            open_q    <= '0;
            rrd_q     <= RRD_SAT;
            act_q     <= 1'b0;
            pre_q     <= 1'b0;
            cke_q     <= 1'b0;
            ras_cmd_q <= 1'b1;
            we_cmd_q  <= 1'b1;
            ba_q      <= '0;
            addr_q    <= '0;
            for (int b = 0; b < NB; b++) begin
                row_tab_q[b] <= '0;
                ras_cnt_q[b] <= RAS_SAT;
            end
        end else begin
            if (accept) begin
                bank_q <= REQ_BANK;
                row_q  <= REQ_ROW;
                hit_q  <= hit_now;
            end
            act_q     <= act_d;
            pre_q     <= pre_d;
            cke_q     <= 1'b1;
            rrd_q     <= act_d ? '0 : rrd_inc;
            for (int b = 0; b < NB; b++) begin
                ras_cnt_q[b] <= (act_d && (cur_bank == BANK_W'(b))) ? '0 : ras_inc[b];
            end
            if (act_d) begin
                open_q[cur_bank]    <= 1'b1;
                row_tab_q[cur_bank] <= cur_row;
            end
            if (pre_d) begin
                open_q[cur_bank] <= 1'b0;
            end
            ras_cmd_q <= !(act_d || pre_d);
            we_cmd_q  <= !pre_d;
            ba_q      <= (act_d || pre_d) ? cur_bank : '0;
            addr_q    <= act_d ? cur_row : '0;
        end
    end

    assign REQ_READY = cke_q && (state_q == IDLE);
    assign DONE      = (state_q == RESP);
    assign HIT       = DONE && hit_q;
    assign ROW_OPEN  = open_q;
    assign CKE       = cke_q;
    assign RAS       = ras_cmd_q;
    assign CAS       = 1'b1;
    assign WE        = we_cmd_q;
    assign BA        = ba_q;
    assign ADDR      = addr_q;
endmodule

// File: tb/tb_row_activate_ctrl.sv
// Bench for row_activate_ctrl: fixed vector table, reset-abort sequence, and random requests
// checked cycle by cycle against a timing model built from earliest-legal-cycle arithmetic.
module tb_row_activate_ctrl;
    localparam int ROW_W = 13, BANK_W = 2, NB = 4;
    localparam int T_RCD = 3, T_RRD = 2, T_RP = 3, T_RAS = 6;

    logic              clk = 1'b0;
    logic              rst, req_valid;
    logic [BANK_W-1:0] req_bank;
    logic [ROW_W-1:0]  req_row;
    logic              req_ready, done, hit, cke, ras, cas, we;
    logic [NB-1:0]     row_open;
    logic [BANK_W-1:0] ba;
    logic [ROW_W-1:0]  addr;

    row_activate_ctrl #(
        .ROW_W(ROW_W), .BANK_W(BANK_W), .T_RCD(T_RCD), .T_RRD(T_RRD), .T_RP(T_RP), .T_RAS(T_RAS)
    ) dut (
        .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_BANK(req_bank), .REQ_ROW(req_row),
        .REQ_READY(req_ready), .DONE(done), .HIT(hit), .ROW_OPEN(row_open),
        .CKE(cke), .RAS(ras), .CAS(cas), .WE(we), .BA(ba), .ADDR(addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
        bit                hit;
        int                pre_off;
        int                act_off;
        int                done_off;
        logic [NB-1:0]     open_mask;
    } vec_t;

    // reference model: open rows and cycle of last ACTIVE (per bank and global)
    bit               m_open [NB];
    logic [ROW_W-1:0] m_row [NB];
    int               m_bank_act [NB];
    int               m_last_act;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [31:0] word(input bit k, input bit rdy, input bit d, input bit h,
                                         input bit r, input bit c, input bit w,
                                         input logic [BANK_W-1:0] b, input logic [ROW_W-1:0] a);
        return 32'({k, rdy, d, h, r, c, w, b, a});
    endfunction

    function automatic logic [31:0] bus_now();
        return word(cke, req_ready, done, hit, ras, cas, we, ba, addr);
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            m_open[b]     = 1'b0;
            m_row[b]      = '0;
            m_bank_act[b] = -1000;
        end
        m_last_act = -1000;
    endtask

    task automatic plan(input int t0, inout vec_t v);
        int b, p, a;
        b = int'(v.bank);
        if (m_open[b] && m_row[b] == v.row) begin
            v.hit = 1'b1; v.pre_off = 0; v.act_off = 0; v.done_off = 1;
        end else begin
            v.hit = 1'b0;
            if (m_open[b]) begin
                p = imax(t0 + 1, m_bank_act[b] + T_RAS);
                a = imax(p + T_RP, m_last_act + T_RRD);
                v.pre_off = p - t0;
            end else begin
                v.pre_off = 0;
                a = imax(t0 + 1, m_last_act + T_RRD);
            end
            v.act_off     = a - t0;
            v.done_off    = a + T_RCD - t0;
            m_open[b]     = 1'b1;
            m_row[b]      = v.row;
            m_bank_act[b] = a;
            m_last_act    = a;
        end
        v.open_mask = {m_open[3], m_open[2], m_open[1], m_open[0]};
    endtask

    task automatic run_req(input string tag, input vec_t v_in, input bit use_model);
        vec_t v;
        int t0, waited;
        logic [31:0] want;
        v = v_in;
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_ready_wait"}, 32'(waited < 50), 32'd1);
        if (waited >= 50) return;
        req_valid = 1'b1;
        req_bank  = v.bank;
        req_row   = v.row;
        t0 = cyc;
        if (use_model) plan(t0, v);
        for (int off = 1; off <= v.done_off; off++) begin
            @(negedge clk);
            if (off == 1) begin
                req_valid = 1'b0;
                req_bank  = 2'($urandom);
                req_row   = 13'($urandom);
            end
            if (v.pre_off != 0 && off == v.pre_off)
                want = word(1, 0, 0, 0, 0, 1, 0, v.bank, '0);
            else if (v.act_off != 0 && off == v.act_off)
                want = word(1, 0, 0, 0, 0, 1, 1, v.bank, v.row);
            else
                want = word(1, 0, off == v.done_off, (off == v.done_off) && v.hit, 1, 1, 1, '0, '0);
            check($sformatf("%s_off%0d_bus", tag, off), bus_now(), want);
            if (off == v.done_off)
                check({tag, "_row_open"}, 32'(row_open), 32'(v.open_mask));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_bus", bus_now(), word(0, 0, 0, 0, 1, 1, 1, '0, '0));
        check("reset_row_open", 32'(row_open), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_bus", bus_now(), word(1, 1, 0, 0, 1, 1, 1, '0, '0));
    endtask

    vec_t vecs [6];
    logic [ROW_W-1:0] rows [3];

    initial begin
        vec_t v;
        // bank, row, hit, pre_off, act_off, done_off, row_open after (offsets from accept cycle)
        vecs[0] = '{2'd1, 13'h0123, 1'b0, 0, 1, 4, 4'b0010};
        vecs[1] = '{2'd1, 13'h0200, 1'b0, 2, 5, 8, 4'b0010};
        vecs[2] = '{2'd1, 13'h0200, 1'b1, 0, 0, 1, 4'b0010};
        vecs[3] = '{2'd0, 13'h0055, 1'b0, 0, 1, 4, 4'b0011};
        vecs[4] = '{2'd2, 13'h1FFF, 1'b0, 0, 1, 4, 4'b0111};
        vecs[5] = '{2'd0, 13'h0056, 1'b0, 1, 4, 7, 4'b0111};
        rows[0] = 13'h0010; rows[1] = 13'h0A5A; rows[2] = 13'h1FFF;

        rst = 1'b1; req_valid = 1'b0; req_bank = '0; req_row = '0;
        do_reset();

        for (int i = 0; i < 6; i++) run_req($sformatf("vec%0d", i), vecs[i], 1'b0);

        // reset while waiting for tRCD aborts the request
        @(negedge clk);
        check("abort_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_bank = 2'd3; req_row = 13'h0AAA;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_active", bus_now(), word(1, 0, 0, 0, 0, 1, 1, 2'd3, 13'h0AAA));
        @(negedge clk);
        check("abort_wait_rcd", bus_now(), word(1, 0, 0, 0, 1, 1, 1, '0, '0));
        rst = 1'b1;
        @(negedge clk);
        check("abort_in_reset", bus_now(), word(0, 0, 0, 0, 1, 1, 1, '0, '0));
        check("abort_row_open", 32'(row_open), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_released", bus_now(), word(1, 1, 0, 0, 1, 1, 1, '0, '0));
        v = '{2'd3, 13'h0AAA, 1'b0, 0, 1, 4, 4'b1000};
        run_req("reopen", v, 1'b0);

        do_reset();
        model_reset();
        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            v = '{2'($urandom_range(0, 3)), rows[$urandom_range(0, 2)], 1'b0, 0, 0, 0, '0};
            run_req($sformatf("rnd%0d", i), v, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
